cim_tile_accum_mem: RTL and testbench
=====================================

Name: cim_tile_accum_mem

Overview:
Parametrised single-clock CIM tile memory.
- Stores TILE_DIM x TILE_DIM signed tiles, one tile per word, from NUM_CH PE write channels, arbitrated round-robin with a valid/ready handshake.
- Supports plain tile write and read-modify-write accumulate, where the incoming tile is added element-wise to the stored tile.
- The off-chip scan port loads and dumps words for test and for weight/partial-sum preload.

Parameters:
NUM_CH, 2, number of PE write channels
TILE_DIM, 6, tile edge length
DATA_W, 12, signed element width
DEPTH, 128, number of tile words
ADDR_W, $clog2(DEPTH), address width
SCAN_W, 512, scan bus width; must be >= TILE_BITS = TILE_DIM*TILE_DIM*DATA_W (432 by default)

Ports:
clk  in  1  single clock
rst_n  in  1  synchronous active-low reset
pe_tile_i  in  NUM_CH*TILE_BITS  packed tiles; element [r][c] of channel k sits at bits k*TILE_BITS + (r*TILE_DIM+c)*DATA_W
pe_addr_i  in  NUM_CH*ADDR_W  target word per channel
pe_acc_i  in  NUM_CH  1 = accumulate, 0 = overwrite
pe_valid_i  in  NUM_CH  request valid
pe_ready_o  out  NUM_CH  grant; a transfer occurs when valid&ready
scan_mode  in  2  00 scan write, 01 PE mode, 10 hold, 11 scan read
scan_en  in  1  qualifies scan write/read
scan_addr  in  ADDR_W  scan word address
scan_in  in  SCAN_W  scan write data; bits [TILE_BITS-1:0] used
scan_out  out  SCAN_W  scan read data, zero-extended above TILE_BITS
scan_valid_o  out  1  scan_out valid pulse
busy_o  out  1  high while in ACC_WB
sat_o  out  1  sticky accumulate-overflow flag

Behaviour:
- Reset (rst_n=0 at posedge):
  - scan_out=0, scan_valid_o=0, pe_ready_o=0, busy_o=0, sat_o=0.
  - Round-robin pointer = channel 0, state = IDLE.
  - Memory contents are not reset.
  - Reset mid-RMW aborts the write-back; the target word keeps its old value.
- States:
  - IDLE: scan_mode != 01, or no channel valid.
  - GRANT: PE mode with at least one valid channel.
  - ACC_WB: accumulate write-back.
- Arbitration (GRANT, combinational):
  - pe_ready_o is one-hot to the first valid channel at or after the pointer, wrapping at NUM_CH.
  - After a grant, pointer = granted channel + 1 mod NUM_CH.
  - pe_ready_o is all-zero outside PE mode and while in ACC_WB.
- Overwrite (acc=0): mem[addr] <= tile at the grant edge. State stays GRANT/IDLE. One grant per cycle.
- Accumulate (acc=1):
  - Grant edge: registers tile, addr and mem[addr]; enters ACC_WB.
  - Next edge: mem[addr] <= element-wise sum; returns to GRANT/IDLE.
  - busy_o=1 during ACC_WB; no grant in that cycle.
  - Back-to-back accumulates to the same address see the updated value, since transfers are serialised.
- ACC_WB always completes, even if scan_mode changes in that cycle.
- A scan write requested during ACC_WB is ignored; the scan side must watch busy_o.
- Scan write: scan_mode=00 & scan_en → mem[scan_addr] <= scan_in[TILE_BITS-1:0] at the edge.
- Scan read: scan_mode=11 & scan_en → scan_out <= {0, mem[scan_addr]} and scan_valid_o=1 on the next cycle (1-cycle latency). Otherwise scan_valid_o=0 and scan_out holds.
- Hold (10): no memory access; outputs hold.
- Sum width: computed in DATA_W+1 bits. Overflow handling is per the Optional Feature.
- Addresses >= DEPTH (non-power-of-2 DEPTH): the write is dropped and a read returns 0.

Optional Feature:
Macro: CIM_MEM_ACC_SAT_EN.
- Defined:
  - Each accumulated element saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Any saturation sets sat_o. sat_o is sticky and cleared only by reset.
- Undefined:
  - Sums wrap modulo 2^DATA_W.
  - sat_o is tied 0.

Test Plan:
1. Scan write word i = i for i=0..127, then scan read all → scan_out = i (zero-extended), with scan_valid_o one cycle after each request.
2. PE mode, both channels valid every cycle; ch0 writes 0xCC-filled tile to addr 3, ch1 writes 0xDD-filled tile to addr 4 → grants alternate ch0, ch1, ch0, … starting at ch0 after reset. Scan read: word 3 all 0xCC, word 4 all 0xDD.
3. Preload word 5 with all elements 0x100; ch0 accumulates a tile of all 0x050 to addr 5 → busy_o high for 1 cycle, no grant that cycle, word 5 = all 0x150.
4. Two consecutive accumulates of all 0x001 to addr 6, from ch0 then ch1, with word 6 preloaded to 0 → word 6 = all 0x002.
5. Word 7 = all 0x7FF, accumulate all 0x001:
   - With CIM_MEM_ACC_SAT_EN: word 7 = 0x7FF, sat_o=1.
   - Without: word 7 = 0x800, sat_o=0.
6. Assert rst_n low in the ACC_WB cycle of an accumulate to addr 9 (preloaded 0x010, adding 0x020) → word 9 stays 0x010, all outputs 0, pointer back at ch0.

Source files
------------

// File: rtl/cim_tile_accum_mem.sv
// CIM tile memory: round-robin PE tile write / read-modify-write accumulate plus scan load/dump port.
// Build option CIM_MEM_ACC_SAT_EN: accumulates saturate and set sticky sat_o; otherwise sums wrap and sat_o=0.
//
// state     | meaning
// ST_IDLE   | not in PE mode, or no channel valid
// ST_GRANT  | PE mode with at least one channel requesting
// ST_ACC_WB | accumulate write-back of the registered sum; no grant
module cim_tile_accum_mem #(
   parameter int NUM_CH   = 2,
   parameter int TILE_DIM = 6,
   parameter int DATA_W   = 12,
   parameter int DEPTH    = 128,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int SCAN_W   = 512
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic [NUM_CH*TILE_DIM*TILE_DIM*DATA_W-1:0] pe_tile_i,
   input  logic [NUM_CH*ADDR_W-1:0]                   pe_addr_i,
   input  logic [NUM_CH-1:0]                          pe_acc_i,
   input  logic [NUM_CH-1:0]                          pe_valid_i,
   output logic [NUM_CH-1:0]                          pe_ready_o,
   input  logic [1:0]                                 scan_mode,
   input  logic                                       scan_en,
   input  logic [ADDR_W-1:0]                          scan_addr,
   input  logic [SCAN_W-1:0]                          scan_in,
   output logic [SCAN_W-1:0]                          scan_out,
   output logic                                       scan_valid_o,
   output logic                                       busy_o,
   output logic                                       sat_o
);

   localparam int ELEMS     = TILE_DIM * TILE_DIM;
   localparam int TILE_BITS = ELEMS * DATA_W;
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [ADDR_W:0] DEPTH_L      = (ADDR_W+1)'(DEPTH);
   localparam logic [1:0]      MODE_SCAN_WR = 2'b00;
   localparam logic [1:0]      MODE_PE      = 2'b01;
   localparam logic [1:0]      MODE_SCAN_RD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT  = 2'd1,
      ST_ACC_WB = 2'd2
   } state_t;

   state_t                 state_q;
   logic [CH_W-1:0]        ptr_q;
   logic [TILE_BITS-1:0]   mem [DEPTH];

   logic [ADDR_W-1:0]      acc_addr_q;
   logic [TILE_BITS-1:0]   acc_tile_q;
   logic [TILE_BITS-1:0]   acc_old_q;

   logic                   arb_en;
   logic                   gnt_any;
   logic                   gnt;
   logic [CH_W-1:0]        gnt_idx;
   logic [TILE_BITS-1:0]   g_tile;
   logic [ADDR_W-1:0]      g_addr;
   logic                   g_acc;
   logic [TILE_BITS-1:0]   g_old;
   logic [TILE_BITS-1:0]   scan_rdata;
   logic                   scan_rd;

   logic                   mem_we;
   logic [ADDR_W-1:0]      mem_waddr;
   logic [TILE_BITS-1:0]   mem_wdata;

   logic [DATA_W:0]        elem_sum;
   logic [TILE_BITS-1:0]   wb_data;

   function automatic logic [CH_W-1:0] ch_wrap(input int base, input int ofs);
      int s;
      s = base + ofs;
      if (s >= NUM_CH) s = s - NUM_CH;
      return CH_W'(s);
   endfunction

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < DEPTH_L);
   endfunction

   // Round-robin: first valid channel at or after the pointer.
   assign arb_en = rst_n && (scan_mode == MODE_PE) && (state_q != ST_ACC_WB);

   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = ptr_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!gnt_any && pe_valid_i[ch_wrap(int'(ptr_q), i)]) begin
            gnt_any = 1'b1;
            gnt_idx = ch_wrap(int'(ptr_q), i);
         end
      end
   end

   assign gnt = arb_en && gnt_any;

   always_comb begin
      pe_ready_o = '0;
      if (gnt) pe_ready_o[gnt_idx] = 1'b1;
   end

   assign g_tile     = pe_tile_i[int'(gnt_idx)*TILE_BITS +: TILE_BITS];
   assign g_addr     = pe_addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
   assign g_acc      = pe_acc_i[gnt_idx];
   assign g_old      = in_range(g_addr) ? mem[g_addr] : '0;
   assign scan_rd    = (scan_mode == MODE_SCAN_RD) && scan_en;
   assign scan_rdata = in_range(scan_addr) ? mem[scan_addr] : '0;

`ifdef CIM_MEM_ACC_SAT_EN
   localparam logic [DATA_W-1:0] EL_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] EL_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   logic wb_ovf;

   // Sign-extended add; the two top bits disagree exactly when the element overflowed.
   always_comb begin
      elem_sum = '0;
      wb_data  = '0;
      wb_ovf   = 1'b0;
      for (int e = 0; e < ELEMS; e++) begin
         elem_sum = {acc_old_q[e*DATA_W+DATA_W-1], acc_old_q[e*DATA_W +: DATA_W]}
                  + {acc_tile_q[e*DATA_W+DATA_W-1], acc_tile_q[e*DATA_W +: DATA_W]};
         if (elem_sum[DATA_W] != elem_sum[DATA_W-1]) begin
            wb_ovf = 1'b1;
            wb_data[e*DATA_W +: DATA_W] = elem_sum[DATA_W] ? EL_MIN : EL_MAX;
         end else begin
            wb_data[e*DATA_W +: DATA_W] = elem_sum[DATA_W-1:0];
         end
      end
   end
`else
   always_comb begin
      elem_sum = '0;
      wb_data  = '0;
      for (int e = 0; e < ELEMS; e++) begin
         elem_sum = {acc_old_q[e*DATA_W+DATA_W-1], acc_old_q[e*DATA_W +: DATA_W]}
                  + {acc_tile_q[e*DATA_W+DATA_W-1], acc_tile_q[e*DATA_W +: DATA_W]};
         wb_data[e*DATA_W +: DATA_W] = elem_sum[DATA_W-1:0];
      end
   end
`endif

   // Single write port; write-back wins and locks out scan writes for that cycle.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      if (state_q == ST_ACC_WB) begin
         mem_we    = 1'b1;
         mem_waddr = acc_addr_q;
         mem_wdata = wb_data;
      end else if (gnt && !g_acc) begin
         mem_we    = 1'b1;
         mem_waddr = g_addr;
         mem_wdata = g_tile;
      end else if ((scan_mode == MODE_SCAN_WR) && scan_en) begin
         mem_we    = 1'b1;
         mem_waddr = scan_addr;
         mem_wdata = scan_in[TILE_BITS-1:0];
      end
      if (!rst_n || !in_range(mem_waddr)) mem_we = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk) begin
      if (gnt && g_acc) begin
         acc_addr_q <= g_addr;
         acc_tile_q <= g_tile;
         acc_old_q  <= g_old;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         ptr_q        <= '0;
         scan_out     <= '0;
         scan_valid_o <= 1'b0;
      end else begin
         scan_valid_o <= 1'b0;
         if (scan_rd) begin
            scan_out     <= SCAN_W'(scan_rdata);
            scan_valid_o <= 1'b1;
         end
         if (gnt) ptr_q <= ch_wrap(int'(gnt_idx), 1);
         if (gnt && g_acc)
            state_q <= ST_ACC_WB;
         else if ((scan_mode == MODE_PE) && (|pe_valid_i))
            state_q <= ST_GRANT;
         else
            state_q <= ST_IDLE;
      end
   end

   assign busy_o = (state_q == ST_ACC_WB);

`ifdef CIM_MEM_ACC_SAT_EN
   logic sat_q;

   always_ff @(posedge clk) begin
      if (!rst_n)
         sat_q <= 1'b0;
      else if ((state_q == ST_ACC_WB) && wb_ovf)
         sat_q <= 1'b1;
   end

   assign sat_o = sat_q;
`else
   assign sat_o = 1'b0;
`endif

   generate
      if (SCAN_W > TILE_BITS) begin : g_scan_pad
         logic unused_scan_hi;
         assign unused_scan_hi = ^scan_in[SCAN_W-1:TILE_BITS];
      end
   endgenerate

endmodule

// File: tb/tb_cim_tile_accum_mem.sv
// Testbench for cim_tile_accum_mem: directed scenarios plus randomized traffic against an element-level memory model.
module tb_cim_tile_accum_mem;

   localparam int NUM_CH    = 2;
   localparam int TILE_DIM  = 6;
   localparam int DATA_W    = 12;
   localparam int DEPTH     = 128;
   localparam int ADDR_W    = 7;
   localparam int SCAN_W    = 512;
   localparam int ELEMS     = TILE_DIM * TILE_DIM;
   localparam int TILE_BITS = ELEMS * DATA_W;
   localparam int EMAX      = (1 << (DATA_W-1)) - 1;
   localparam int EMIN      = -(1 << (DATA_W-1));

   logic                          clk = 1'b0;
   logic                          rst_n;
   logic [NUM_CH*TILE_BITS-1:0]   pe_tile_i;
   logic [NUM_CH*ADDR_W-1:0]      pe_addr_i;
   logic [NUM_CH-1:0]             pe_acc_i;
   logic [NUM_CH-1:0]             pe_valid_i;
   logic [NUM_CH-1:0]             pe_ready_o;
   logic [1:0]                    scan_mode;
   logic                          scan_en;
   logic [ADDR_W-1:0]             scan_addr;
   logic [SCAN_W-1:0]             scan_in;
   logic [SCAN_W-1:0]             scan_out;
   logic                          scan_valid_o;
   logic                          busy_o;
   logic                          sat_o;

   always #5 clk = ~clk;

   cim_tile_accum_mem #(
      .NUM_CH(NUM_CH), .TILE_DIM(TILE_DIM), .DATA_W(DATA_W),
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SCAN_W(SCAN_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .pe_tile_i(pe_tile_i), .pe_addr_i(pe_addr_i), .pe_acc_i(pe_acc_i),
      .pe_valid_i(pe_valid_i), .pe_ready_o(pe_ready_o),
      .scan_mode(scan_mode), .scan_en(scan_en), .scan_addr(scan_addr),
      .scan_in(scan_in), .scan_out(scan_out), .scan_valid_o(scan_valid_o),
      .busy_o(busy_o), .sat_o(sat_o)
   );

   // Reference model: memory as signed integer elements
   int               mm [DEPTH][ELEMS];
   int               in_tile [NUM_CH][ELEMS];
   int               in_addr [NUM_CH];
   int               sc_tile [ELEMS];
   int               m_ptr;
   bit               m_busy;
   int               m_pend_addr;
   int               m_pend [ELEMS];
   bit               m_sat;
   logic [SCAN_W-1:0] m_out;
   bit               m_valid;

   int checks;
   int errors;

   function automatic int wrap_el(input int s);
      int w;
      w = s & ((1 << DATA_W) - 1);
      if (w > EMAX) w = w - (1 << DATA_W);
      return w;
   endfunction

   function automatic logic [SCAN_W-1:0] word_of(input int a);
      logic [SCAN_W-1:0] r;
      r = '0;
      for (int e = 0; e < ELEMS; e++) r[e*DATA_W +: DATA_W] = DATA_W'(mm[a][e]);
      return r;
   endfunction

   function automatic logic [SCAN_W-1:0] fill_word(input int v);
      logic [SCAN_W-1:0] r;
      r = '0;
      for (int e = 0; e < ELEMS; e++) r[e*DATA_W +: DATA_W] = DATA_W'(v);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [SCAN_W-1:0] obs, input logic [SCAN_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_inputs();
      for (int ch = 0; ch < NUM_CH; ch++) begin
         for (int e = 0; e < ELEMS; e++)
            pe_tile_i[ch*TILE_BITS + e*DATA_W +: DATA_W] = DATA_W'(in_tile[ch][e]);
         pe_addr_i[ch*ADDR_W +: ADDR_W] = ADDR_W'(in_addr[ch]);
      end
      for (int e = 0; e < ELEMS; e++) scan_in[e*DATA_W +: DATA_W] = DATA_W'(sc_tile[e]);
      for (int b = TILE_BITS; b < SCAN_W; b++) scan_in[b] = 1'($urandom_range(0, 1));
   endtask

   // One clock: check combinational grant, advance the model, check registered outputs.
   task automatic step();
      logic [NUM_CH-1:0] er;
      int g;
      int s;
      apply_inputs();
      #1;
      er = '0;
      g  = -1;
      if (rst_n && scan_mode == 2'b01 && !m_busy) begin
         for (int i = 0; i < NUM_CH; i++) begin
            int c;
            c = (m_ptr + i) % NUM_CH;
            if (g < 0 && pe_valid_i[c]) g = c;
         end
      end
      if (g >= 0) er[g] = 1'b1;
      chk("pe_ready", SCAN_W'(pe_ready_o), SCAN_W'(er));
      if (!rst_n) begin
         m_ptr = 0; m_busy = 0; m_out = '0; m_valid = 0; m_sat = 0;
      end else begin
         m_valid = 0;
         if (scan_mode == 2'b11 && scan_en) begin
            m_out   = word_of(int'(scan_addr));
            m_valid = 1;
         end
         if (m_busy) begin
            for (int e = 0; e < ELEMS; e++) begin
               s = mm[m_pend_addr][e] + m_pend[e];
`ifdef CIM_MEM_ACC_SAT_EN
               if (s > EMAX) begin s = EMAX; m_sat = 1; end
               else if (s < EMIN) begin s = EMIN; m_sat = 1; end
`else
               s = wrap_el(s);
`endif
               mm[m_pend_addr][e] = s;
            end
            m_busy = 0;
         end else if (scan_mode == 2'b00 && scan_en) begin
            for (int e = 0; e < ELEMS; e++) mm[scan_addr][e] = sc_tile[e];
         end else if (g >= 0) begin
            m_ptr = (g + 1) % NUM_CH;
            if (pe_acc_i[g]) begin
               m_busy      = 1;
               m_pend_addr = in_addr[g];
               for (int e = 0; e < ELEMS; e++) m_pend[e] = in_tile[g][e];
            end else begin
               for (int e = 0; e < ELEMS; e++) mm[in_addr[g]][e] = in_tile[g][e];
            end
         end
      end
      @(posedge clk);
      #1;
      chk("scan_valid", SCAN_W'(scan_valid_o), SCAN_W'(m_valid));
      chk("scan_out", scan_out, m_out);
      chk("busy", SCAN_W'(busy_o), SCAN_W'(m_busy));
      chk("sat", SCAN_W'(sat_o), SCAN_W'(m_sat));
   endtask

   task automatic set_fill(input int ch, input int v, input int a);
      for (int e = 0; e < ELEMS; e++) in_tile[ch][e] = v;
      in_addr[ch] = a;
   endtask

   task automatic scan_write_fill(input int a, input int v);
      scan_mode = 2'b00; scan_en = 1'b1; scan_addr = ADDR_W'(a);
      for (int e = 0; e < ELEMS; e++) sc_tile[e] = v;
      step();
      scan_en = 1'b0; scan_mode = 2'b10;
   endtask

   task automatic scan_read(input int a);
      scan_mode = 2'b11; scan_en = 1'b1; scan_addr = ADDR_W'(a);
      step();
      scan_en = 1'b0; scan_mode = 2'b10;
   endtask

   initial begin
      checks = 0; errors = 0;
      m_ptr = 0; m_busy = 0; m_pend_addr = 0; m_sat = 0; m_out = '0; m_valid = 0;
      for (int e = 0; e < ELEMS; e++) begin sc_tile[e] = 0; m_pend[e] = 0; end
      for (int ch = 0; ch < NUM_CH; ch++) set_fill(ch, 0, 0);
      rst_n = 1'b0; scan_mode = 2'b01; scan_en = 1'b0; scan_addr = '0;
      pe_valid_i = '0; pe_acc_i = '0; pe_tile_i = '0; pe_addr_i = '0; scan_in = '0;

      step();
      step();
      chk("rst_scan_out", scan_out, '0);
      chk("rst_flags", SCAN_W'({scan_valid_o, busy_o, sat_o}), '0);
      rst_n = 1'b1;
      scan_mode = 2'b10;

      // Word i holds value i
      scan_mode = 2'b00; scan_en = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         scan_addr = ADDR_W'(i);
         for (int e = 0; e < ELEMS; e++) sc_tile[e] = 0;
         sc_tile[0] = i;
         step();
      end
      scan_mode = 2'b11;
      for (int i = 0; i < DEPTH; i++) begin
         scan_addr = ADDR_W'(i);
         step();
         chk("t1_word", scan_out, SCAN_W'(i));
         chk("t1_valid", SCAN_W'(scan_valid_o), SCAN_W'(1));
      end
      scan_en = 1'b0;
      step();
      chk("t1_hold_out", scan_out, SCAN_W'(DEPTH-1));
      chk("t1_valid_low", SCAN_W'(scan_valid_o), '0);

      // Both channels overwrite every cycle; grants alternate from ch0
      scan_mode = 2'b01; pe_acc_i = '0; pe_valid_i = 2'b11;
      set_fill(0, 'h0CC, 3);
      set_fill(1, 'h0DD, 4);
      for (int k = 0; k < 6; k++) begin
         apply_inputs();
         #1;
         chk("t2_rr", SCAN_W'(pe_ready_o), SCAN_W'((k % 2 == 0) ? 2'b01 : 2'b10));
         step();
      end
      pe_valid_i = '0;
      scan_read(3);
      chk("t2_word3", scan_out, fill_word('h0CC));
      scan_read(4);
      chk("t2_word4", scan_out, fill_word('h0DD));

      // Accumulate 0x100 + 0x050; busy for one cycle with no grant
      scan_write_fill(5, 'h100);
      scan_mode = 2'b01; pe_valid_i = 2'b01; pe_acc_i = 2'b01;
      set_fill(0, 'h050, 5);
      set_fill(1, 'h3AB, 20);
      step();
      chk("t3_busy", SCAN_W'(busy_o), SCAN_W'(1));
      pe_valid_i = 2'b11; pe_acc_i = 2'b01;
      apply_inputs();
      #1;
      chk("t3_no_grant", SCAN_W'(pe_ready_o), '0);
      step();
      chk("t3_busy_done", SCAN_W'(busy_o), '0);
      pe_valid_i = '0;
      step();
      scan_read(5);
      chk("t3_word5", scan_out, fill_word('h150));

      // Overflow boundary: 0x7FF + 1
      scan_write_fill(7, 'h7FF);
      scan_mode = 2'b01; pe_valid_i = 2'b01; pe_acc_i = 2'b01;
      set_fill(0, 1, 7);
      step();
      pe_valid_i = '0;
      step();
      scan_read(7);
`ifdef CIM_MEM_ACC_SAT_EN
      chk("t5_word7", scan_out, fill_word('h7FF));
      chk("t5_sat", SCAN_W'(sat_o), SCAN_W'(1));
`else
      chk("t5_word7", scan_out, fill_word('h800));
      chk("t5_sat", SCAN_W'(sat_o), '0);
`endif

      // Reset during write-back aborts it
      scan_write_fill(9, 'h010);
      scan_mode = 2'b01; pe_valid_i = 2'b01; pe_acc_i = 2'b01;
      set_fill(0, 'h020, 9);
      step();
      chk("t6_busy", SCAN_W'(busy_o), SCAN_W'(1));
      rst_n = 1'b0; pe_valid_i = '0;
      step();
      chk("t6_rst_out", scan_out, '0);
      chk("t6_rst_flags", SCAN_W'({scan_valid_o, busy_o, sat_o}), '0);
      rst_n = 1'b1;
      scan_read(9);
      chk("t6_word9", scan_out, fill_word('h010));

      // Back-to-back accumulates to one word; pointer restarted at ch0
      scan_write_fill(6, 0);
      scan_mode = 2'b01; pe_valid_i = 2'b11; pe_acc_i = 2'b11;
      set_fill(0, 1, 6);
      set_fill(1, 1, 6);
      apply_inputs();
      #1;
      chk("t4_first_ch0", SCAN_W'(pe_ready_o), SCAN_W'(2'b01));
      step();
      step();
      apply_inputs();
      #1;
      chk("t4_second_ch1", SCAN_W'(pe_ready_o), SCAN_W'(2'b10));
      step();
      pe_valid_i = '0;
      step();
      scan_read(6);
      chk("t4_word6", scan_out, fill_word(2));

      // Randomized traffic over a small address window
      for (int n = 0; n < 600; n++) begin
         int r;
         r = int'($urandom_range(0, 9));
         scan_mode  = (r < 2) ? 2'b00 : (r < 7) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
         scan_en    = ($urandom_range(0, 3) != 0);
         scan_addr  = ADDR_W'($urandom_range(0, 15));
         pe_valid_i = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
         pe_acc_i   = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
         for (int e = 0; e < ELEMS; e++) sc_tile[e] = int'($urandom_range(0, 4095)) - 2048;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            in_addr[ch] = int'($urandom_range(0, 15));
            for (int e = 0; e < ELEMS; e++) in_tile[ch][e] = int'($urandom_range(0, 4095)) - 2048;
         end
         rst_n = ($urandom_range(0, 99) != 0);
         step();
      end
      rst_n = 1'b1; pe_valid_i = '0;
      for (int i = 0; i < 16; i++) scan_read(i);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
